// File: rtl/ex_mem_pkg.sv
// Shared definitions for the execute/memory pipeline: ALU opcodes and default sizes.
package ex_mem_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_REG_IDX_W = 4;
  localparam int ALU_OP_W      = 8;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD   = 8'd0,
    OP_SUB   = 8'd1,
    OP_AND   = 8'd2,
    OP_OR    = 8'd3,
    OP_XOR   = 8'd4,
    OP_SHL   = 8'd5,
    OP_SHR   = 8'd6,
    OP_SLT   = 8'd7,
    OP_PASSB = 8'd8
  } alu_op_e;

endpackage

// File: rtl/ex_mem_if.sv
// Instruction-in / result-out handshake bundle of the execute/memory pipeline.
interface ex_mem_if
  import ex_mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int REG_IDX_W = DEF_REG_IDX_W
);

  logic                 in_valid;
  logic                 in_ready;
  logic [ALU_OP_W-1:0]  in_alu_op;
  logic                 in_use_imm;
  logic [DATA_W-1:0]    in_a;
  logic [DATA_W-1:0]    in_b;
  logic [DATA_W-1:0]    in_imm;
  logic                 in_mem_rd;
  logic                 in_mem_wr;
  logic [REG_IDX_W-1:0] in_rd;
  logic                 in_rd_we;
  logic [REG_IDX_W-1:0] in_rs_a;
  logic [REG_IDX_W-1:0] in_rs_b;

  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_result;
  logic [REG_IDX_W-1:0] out_rd;
  logic                 out_rd_we;

  modport master (
    output in_valid, in_alu_op, in_use_imm, in_a, in_b, in_imm,
           in_mem_rd, in_mem_wr, in_rd, in_rd_we, in_rs_a, in_rs_b,
           out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_rd_we
  );

  modport slave (
    input  in_valid, in_alu_op, in_use_imm, in_a, in_b, in_imm,
           in_mem_rd, in_mem_wr, in_rd, in_rd_we, in_rs_a, in_rs_b,
           out_ready,
    output in_ready, out_valid, out_result, out_rd, out_rd_we
  );

endinterface

// File: rtl/ex_mem_alu.sv
// Combinational ALU; every result is taken modulo 2^DATA_W, unknown opcodes give 0.
module ex_mem_alu
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [DATA_W-1:0]   y
);

  localparam int SH_W = $clog2(DATA_W);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic        [SH_W-1:0]   sh;

  function automatic logic [DATA_W-1:0] slt_fn(input logic signed [DATA_W-1:0] x,
                                               input logic signed [DATA_W-1:0] z);
    return {{(DATA_W-1){1'b0}}, (x < z)};
  endfunction

  assign a_s = a;
  assign b_s = b;
  // Shift distance only uses enough bits to address one word.
  assign sh  = b[SH_W-1:0];

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:   y = a + b;
      OP_SUB:   y = a - b;
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_SHL:   y = a << sh;
      OP_SHR:   y = a >> sh;
      OP_SLT:   y = slt_fn(a_s, b_s);
      OP_PASSB: y = b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// Two-stage execute/memory pipeline with valid/ready flow control on both sides.
// Define EX_MEM_FWD_EN to add S1/S2 operand forwarding and the load-use stall.
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int REG_IDX_W = DEF_REG_IDX_W
) (
  input logic     clk,
  input logic     rst,
  ex_mem_if.slave bus
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);

  logic                 adv;
  logic                 stall;
  logic                 accept;

  logic [DATA_W-1:0]    opa_p0;
  logic [DATA_W-1:0]    opb_p0;
  logic [DATA_W-1:0]    bsel_p0;
  logic [DATA_W-1:0]    alu_p0;

  logic                 vld_p1;
  logic                 ld_p1;
  logic                 st_p1;
  logic                 rd_we_p1;
  logic [REG_IDX_W-1:0] rd_p1;
  logic [DATA_W-1:0]    alu_p1;
  logic [DATA_W-1:0]    b_p1;
  logic [ADDR_W-1:0]    addr_p1;

  logic                 vld_p2;
  logic                 ld_p2;
  logic                 rd_we_p2;
  logic [REG_IDX_W-1:0] rd_p2;
  logic [DATA_W-1:0]    alu_p2;
  logic [DATA_W-1:0]    rdata_p2;
  logic [DATA_W-1:0]    res_p2;

  logic [DATA_W-1:0]    mem [MEM_DEPTH];

  // Both stages move together whenever the output slot is free or being drained.
  assign adv          = !vld_p2 || bus.out_ready;
  assign bus.in_ready = adv && !stall;
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef EX_MEM_FWD_EN
  logic a_s1, b_s1, a_s2, b_s2;

  function automatic logic idx_hit(input logic [REG_IDX_W-1:0] rs,
                                   input logic [REG_IDX_W-1:0] rd,
                                   input logic                 vld,
                                   input logic                 we);
    return (rs != '0) && vld && we && (rs == rd);
  endfunction

  // A load in S1 has no data yet: stall one cycle and pick it up from S2.
  always_comb begin
    a_s1   = idx_hit(bus.in_rs_a, rd_p1, vld_p1, rd_we_p1);
    b_s1   = idx_hit(bus.in_rs_b, rd_p1, vld_p1, rd_we_p1);
    a_s2   = idx_hit(bus.in_rs_a, rd_p2, vld_p2, rd_we_p2);
    b_s2   = idx_hit(bus.in_rs_b, rd_p2, vld_p2, rd_we_p2);
    opa_p0 = bus.in_a;
    opb_p0 = bus.in_b;
    if (a_s1 && !ld_p1)  opa_p0 = alu_p1;
    else if (a_s2)       opa_p0 = res_p2;
    if (b_s1 && !ld_p1)  opb_p0 = alu_p1;
    else if (b_s2)       opb_p0 = res_p2;
    stall  = ld_p1 && (a_s1 || b_s1);
  end
`else
  logic unused_rs;

  assign opa_p0    = bus.in_a;
  assign opb_p0    = bus.in_b;
  assign stall     = 1'b0;
  assign unused_rs = ^{bus.in_rs_a, bus.in_rs_b};
`endif

  // ---- p0: operand select and ALU ----
  assign bsel_p0 = bus.in_use_imm ? bus.in_imm : opb_p0;

  ex_mem_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op (bus.in_alu_op),
    .a  (opa_p0),
    .b  (bsel_p0),
    .y  (alu_p0)
  );

  // ---- p0 -> p1 -> p2 pipeline registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      ld_p1    <= 1'b0;
      st_p1    <= 1'b0;
      rd_we_p1 <= 1'b0;
      rd_p1    <= '0;
      alu_p1   <= '0;
      b_p1     <= '0;
      vld_p2   <= 1'b0;
      ld_p2    <= 1'b0;
      rd_we_p2 <= 1'b0;
      rd_p2    <= '0;
      alu_p2   <= '0;
    end else if (adv) begin
      vld_p1   <= accept;
      ld_p1    <= accept && bus.in_mem_rd;
      st_p1    <= accept && bus.in_mem_wr;
      rd_we_p1 <= accept && bus.in_rd_we && !bus.in_mem_wr;
      rd_p1    <= bus.in_rd;
      alu_p1   <= alu_p0;
      b_p1     <= opb_p0;
      vld_p2   <= vld_p1;
      ld_p2    <= vld_p1 && ld_p1;
      rd_we_p2 <= vld_p1 && rd_we_p1;
      rd_p2    <= rd_p1;
      alu_p2   <= alu_p1;
    end
  end

  // ---- p1 -> p2 memory access ----
  // Write and read fire only on the advance that moves S1 on, so a stalled store
  // writes once and an aborted one never writes.
  assign addr_p1 = alu_p1[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst && adv && vld_p1) begin
      if (st_p1) mem[addr_p1] <= b_p1;
      if (ld_p1) rdata_p2 <= mem[addr_p1];
    end
  end

  // ---- p2: write-back output ----
  assign res_p2         = ld_p2 ? rdata_p2 : alu_p2;
  assign bus.out_valid  = vld_p2;
  assign bus.out_result = res_p2;
  assign bus.out_rd     = rd_p2;
  assign bus.out_rd_we  = rd_we_p2;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: random and directed instructions against a reference model.
module tb_ex_mem_pipe;
  import ex_mem_pkg::*;

  localparam int DW = 16;
  localparam int RW = 4;

  typedef struct {
    logic [7:0]    op;
    logic          use_imm;
    logic [DW-1:0] a, b, imm;
    logic          ld, st;
    logic [RW-1:0] rd, rs_a, rs_b;
    logic          rd_we;
  } instr_t;

  typedef struct {
    logic [DW-1:0] result;
    logic [RW-1:0] rd;
    logic          rd_we;
    int            cyc;
    bit            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   rdy_rand = 1'b0;
  logic ordy = 1'b1;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] rf [16];

  ex_mem_if #(.DATA_W(DW), .REG_IDX_W(RW)) bus ();

  ex_mem_pipe #(.DATA_W(DW), .MEM_DEPTH(256), .REG_IDX_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  function automatic instr_t mk(input logic [7:0] op, input logic use_imm, input logic [DW-1:0] a,
                                input logic [DW-1:0] b, input logic [DW-1:0] imm, input logic ld,
                                input logic st, input logic [RW-1:0] rd, input logic rd_we);
    instr_t t;
    t.op = op; t.use_imm = use_imm; t.a = a; t.b = b; t.imm = imm;
    t.ld = ld; t.st = st; t.rd = rd; t.rd_we = rd_we; t.rs_a = '0; t.rs_b = '0;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    int r;
    logic [7:0] op;
    op = ($urandom_range(0, 9) == 9) ? 8'($urandom_range(9, 255)) : 8'($urandom_range(0, 8));
    r  = $urandom_range(0, 3);
    return mk(op, 1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom), DW'($urandom),
              r == 0, r == 1, RW'($urandom), 1'($urandom_range(0, 1)));
  endfunction

  // Reference: word-level arithmetic on integers, memory as a plain array updated in issue order.
  task automatic model_accept(input instr_t ins, input bit lat, input bit fa);
    longint opa, bs, sa, sbv, r;
    int     sh, addr;
    exp_t   e;
    opa = fa ? longint'(rf[ins.rs_a]) : longint'(ins.a);
    bs  = ins.use_imm ? longint'(ins.imm) : longint'(ins.b);
    sh  = int'(bs % 16);
    sa  = (opa >= 32768) ? opa - 65536 : opa;
    sbv = (bs >= 32768) ? bs - 65536 : bs;
    case (ins.op)
      OP_ADD:   r = (opa + bs) % 65536;
      OP_SUB:   r = (opa - bs + 65536) % 65536;
      OP_AND:   r = longint'(DW'(opa) & DW'(bs));
      OP_OR:    r = longint'(DW'(opa) | DW'(bs));
      OP_XOR:   r = longint'(DW'(opa) ^ DW'(bs));
      OP_SHL:   r = (opa * (longint'(1) << sh)) % 65536;
      OP_SHR:   r = opa / (longint'(1) << sh);
      OP_SLT:   r = (sa < sbv) ? 1 : 0;
      OP_PASSB: r = bs;
      default:  r = 0;
    endcase
    addr = int'(r % 256);
    if (ins.st) ref_mem[addr] = ins.b;
    e.result = ins.ld ? ref_mem[addr] : DW'(r);
    e.rd     = ins.rd;
    e.rd_we  = ins.rd_we && !ins.st;
    e.cyc    = cyc;
    e.lat    = lat;
    if (e.rd_we) rf[ins.rd] = e.result;
    sb.push_back(e);
  endtask

  task automatic drive_out_ready();
    if (rdy_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
    else          bus.out_ready = ordy;
  endtask

  task automatic try_issue(input instr_t ins, input bit lat, input bit fa, output bit acc, output int acyc);
    @(negedge clk);
    bus.in_alu_op = ins.op;  bus.in_use_imm = ins.use_imm;
    bus.in_a = ins.a;  bus.in_b = ins.b;  bus.in_imm = ins.imm;
    bus.in_mem_rd = ins.ld;  bus.in_mem_wr = ins.st;
    bus.in_rd = ins.rd;  bus.in_rd_we = ins.rd_we;
    bus.in_rs_a = ins.rs_a;  bus.in_rs_b = ins.rs_b;
    bus.in_valid = 1'b1;
    drive_out_ready();
    #4;
    acc  = bus.in_ready;
    acyc = cyc;
    if (acc) model_accept(ins, lat, fa);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic issue(input instr_t ins, input bit lat, input bit fa, output int acyc);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      try_issue(ins, lat, fa, acc, acyc);
      n++;
    end
    if (!acc) check("issue_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      drive_out_ready();
    end
  endtask

  task automatic drain();
    int n;
    rdy_rand = 1'b0;
    ordy = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      idle(1);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    idle(2);
  endtask

  // Monitor: pops the scoreboard whenever a result is handed over.
  initial begin : monitor
    exp_t          e;
    bit            head_seen, hold_prev;
    logic [DW-1:0] h_res;
    logic [RW-1:0] h_rd;
    logic          h_we;
    int            lat;
    head_seen = 1'b0;
    hold_prev = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        head_seen = 1'b0;
        hold_prev = 1'b0;
        continue;
      end
      if (hold_prev) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_result", bus.out_result, h_res);
        check("hold_rd", {bus.out_rd_we, bus.out_rd}, {h_we, h_rd});
      end
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_output", bus.out_valid, 0);
        end else begin
          e = sb[0];
          if (!head_seen) begin
            head_seen = 1'b1;
            lat = cyc - e.cyc;
            if (e.lat) check("latency", lat, 2);
            else       check("latency_min", (lat >= 2), 1);
          end
          if (bus.out_ready) begin
            check("result", bus.out_result, e.result);
            check("out_rd", bus.out_rd, e.rd);
            check("out_rd_we", bus.out_rd_we, e.rd_we);
            void'(sb.pop_front());
            head_seen = 1'b0;
          end
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      h_res = bus.out_result;
      h_rd  = bus.out_rd;
      h_we  = bus.out_rd_we;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "time limit");
  end

  initial begin : stim
    instr_t q[3];
    instr_t t;
    int     ac, ac2, k;
    bit     acc;
    logic [DW-1:0] old;

    bus.in_valid = 1'b0;  bus.in_alu_op = '0;  bus.in_use_imm = 1'b0;
    bus.in_a = '0;  bus.in_b = '0;  bus.in_imm = '0;
    bus.in_mem_rd = 1'b0;  bus.in_mem_wr = 1'b0;
    bus.in_rd = '0;  bus.in_rd_we = 1'b0;  bus.in_rs_a = '0;  bus.in_rs_b = '0;
    bus.out_ready = 1'b1;

    #2;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_result", bus.out_result, 0);
    check("rst_out_rd", bus.out_rd, 0);
    check("rst_out_rd_we", bus.out_rd_we, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Fill every memory word through stores so later loads have defined data.
    for (int i = 0; i < 256; i++)
      issue(mk(OP_ADD, 1'b1, DW'(i), DW'($urandom), '0, 1'b0, 1'b1, RW'(i), 1'b1), 1'b1, 1'b0, ac);

    issue(mk(OP_ADD, 1'b1, 16'd5, 16'd0, 16'd3, 1'b0, 1'b0, 4'd2, 1'b1), 1'b1, 1'b0, ac);
    issue(mk(OP_ADD, 1'b1, 16'h0010, 16'hBEEF, 16'd0, 1'b0, 1'b1, 4'd1, 1'b1), 1'b1, 1'b0, ac);
    issue(mk(OP_ADD, 1'b1, 16'h0010, 16'd0, 16'd0, 1'b1, 1'b0, 4'd9, 1'b1), 1'b1, 1'b0, ac);
    issue(mk(OP_SUB, 1'b1, 16'd0, 16'd0, 16'd1, 1'b0, 1'b0, 4'd1, 1'b1), 1'b1, 1'b0, ac);
    issue(mk(OP_ADD, 1'b1, 16'h01FF, 16'hA5A5, 16'd0, 1'b0, 1'b1, 4'd3, 1'b0), 1'b1, 1'b0, ac);
    issue(mk(OP_ADD, 1'b1, 16'h00FF, 16'd0, 16'd0, 1'b1, 1'b0, 4'd5, 1'b1), 1'b1, 1'b0, ac);
    issue(mk(OP_SLT, 1'b0, 16'hFFFF, 16'd1, 16'd0, 1'b0, 1'b0, 4'd6, 1'b1), 1'b1, 1'b0, ac);
    issue(mk(8'hC3, 1'b0, 16'h1234, 16'h5678, 16'd0, 1'b0, 1'b0, 4'd7, 1'b1), 1'b1, 1'b0, ac);
    drain();

    // Back-pressure: 4 cycles of out_ready=0 with 3 instructions offered.
    q[0] = mk(OP_ADD, 1'b1, 16'd1, 16'd0, 16'd1, 1'b0, 1'b0, 4'd5, 1'b1);
    q[1] = mk(OP_ADD, 1'b1, 16'h0040, 16'h7777, 16'd0, 1'b0, 1'b1, 4'd6, 1'b1);
    q[2] = mk(OP_ADD, 1'b1, 16'h0040, 16'd0, 16'd0, 1'b1, 1'b0, 4'd7, 1'b1);
    ordy = 1'b0;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      try_issue(q[k], 1'b0, 1'b0, acc, ac);
      if (acc) k++;
    end
    check("backpressure_accepts", k, 2);
    ordy = 1'b1;
    issue(q[2], 1'b0, 1'b0, ac);
    drain();

    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      issue(rand_instr(), 1'b0, 1'b0, ac);
    end
    drain();

    // Reset while a store is in S1: it must never reach memory.
    old = ref_mem[8'h20];
    @(negedge clk);
    bus.in_alu_op = OP_ADD;  bus.in_use_imm = 1'b1;  bus.in_a = 16'h0020;
    bus.in_b = ~old;  bus.in_imm = '0;  bus.in_mem_rd = 1'b0;  bus.in_mem_wr = 1'b1;
    bus.in_rd = 4'd1;  bus.in_rd_we = 1'b0;  bus.in_rs_a = '0;  bus.in_rs_b = '0;
    bus.in_valid = 1'b1;  bus.out_ready = 1'b1;
    #4 check("rst_store_accept", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    @(negedge clk) rst = 1'b0;
    issue(mk(OP_ADD, 1'b1, 16'h0020, 16'd0, 16'd0, 1'b1, 1'b0, 4'd2, 1'b1), 1'b1, 1'b0, ac);
    drain();

`ifdef EX_MEM_FWD_EN
    issue(mk(OP_ADD, 1'b1, 16'd7, 16'd0, 16'd0, 1'b0, 1'b0, 4'd3, 1'b1), 1'b1, 1'b0, ac);
    t = mk(OP_ADD, 1'b1, 16'd0, 16'd0, 16'd1, 1'b0, 1'b0, 4'd6, 1'b1);
    t.rs_a = 4'd3;
    issue(t, 1'b1, 1'b1, ac2);
    check("fwd_s1_no_stall", ac2 - ac, 1);
    issue(mk(OP_ADD, 1'b1, 16'h0030, 16'd0, 16'd0, 1'b1, 1'b0, 4'd4, 1'b1), 1'b1, 1'b0, ac);
    t = mk(OP_ADD, 1'b1, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 4'd7, 1'b1);
    t.rs_a = 4'd4;
    issue(t, 1'b1, 1'b1, ac2);
    check("load_use_stall", ac2 - ac, 2);
    drain();
`else
    t = mk(OP_ADD, 1'b1, 16'd9, 16'd0, 16'd1, 1'b0, 1'b0, 4'd3, 1'b1);
    t.rs_a = 4'd3;
    issue(t, 1'b1, 1'b0, ac);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised two-stage execute/memory pipeline that succeeds the fixed 16-bit execute/data-memory stage. It selects the ALU B operand (register or extended constant), runs the ALU, and uses the ALU result as the data-memory address for loads and stores. It returns either the ALU result or the loaded word to write-back. Data width, memory depth and register-index width are configurable; the block adds valid/ready flow control and an optional operand-forwarding path.

## Interface
- DATA_W, 16, datapath/ALU/memory word width
- MEM_DEPTH, 256, data-memory words (power of two); ADDR_W = $clog2(MEM_DEPTH)
- REG_IDX_W, 4, register index width
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all pipeline state
- in_valid  in  1  instruction presented
- in_ready  out  1  stage accepts instruction this cycle
- in_alu_op  in  8  ALU operation code (package enum)
- in_use_imm  in  1  1: B operand = in_imm, 0: B operand = in_b
- in_a, in_b, in_imm  in  DATA_W  register operands, sign-extended constant
- in_mem_rd, in_mem_wr  in  1  load / store (mutually exclusive)
- in_rd  in  REG_IDX_W  destination register; in_rd_we  in  1  write-back enable
- in_rs_a, in_rs_b  in  REG_IDX_W  source indices (forwarding only)
- out_valid  out  1  result valid; out_ready  in  1  write-back accepts
- out_result  out  DATA_W  ALU result or load data
- out_rd  out  REG_IDX_W; out_rd_we  out  1

## Operation
- Handshake: transfer occurs on in_valid && in_ready, and likewise on out_valid && out_ready. out_* stay stable while out_valid && !out_ready.
- Advance condition: adv = !s2_valid || out_ready. Both stages move together on adv; in_ready = adv, except during a load-use stall (see Configuration).
- S1 (accept): captures the ALU result of in_a op B_sel, plus in_b (store data) and the control fields.
- S1→S2 on adv with s1_valid:
  - Store writes mem[s1_alu[ADDR_W-1:0]] = s1_b exactly once.
  - Load performs a synchronous read at the same address.
  - S2 captures the ALU result.
- Output mux: out_result = s2_is_load ? mem read data : s2_alu.
- Address: low ADDR_W bits of the ALU result; upper bits are ignored, and the address wraps modulo MEM_DEPTH.
- ALU: all ops modulo 2^DATA_W. Shifts use B[$clog2(DATA_W)-1:0]. SLT is signed and returns 1 or 0. Undefined opcodes return 0.
- Stores force out_rd_we=0 but still produce out_valid. They are never dropped.
- Bubble: when adv && !in_valid, S1 becomes invalid.

## Timing
- Latency is 2 cycles from accept to out_valid, for all ops including loads.
- Throughput is 1 instruction per cycle when out_ready is held high.
- Reset values:
  - in_ready=1 (combinational from adv).
  - out_valid=0, out_result=0, out_rd=0, out_rd_we=0.
  - Internal valids = 0.
  - Memory contents are not reset.
- Reset mid-operation discards both stages. A store still in S1 never writes.
- Back-pressure: while out_ready=0 with S2 full, in_ready=0, S1 holds and no memory write repeats.
- Store followed by load to the same address on the next accepted cycle: the load returns the new data, because the write occurs on the earlier advance.

## Configuration
- Macro: EX_MEM_FWD_EN.
- Defined:
  - A source index (rs_a or rs_b) that is nonzero and matches the rd of a valid S1 instruction with rd_we and no load takes s1_alu.
  - Otherwise, a nonzero index that matches a valid S2 with rd_we takes out_result.
  - S1 has priority over S2.
  - A match on a load in S1 forces in_ready=0 for one cycle (load-use stall). The load then moves to S2 and is forwarded from there.
- Undefined: in_a/in_b are used as presented, rs ports are ignored, and there is no hazard stall.

## Structure
- Package ex_mem_pkg holds the ALU opcode enum (ADD, SUB, AND, OR, XOR, SHL, SHR, SLT, PASSB) and the default parameter constants.
- One sub-module, ex_mem_alu: a parametrised combinational ALU (DATA_W).
- Memory array, pipeline registers and forwarding logic live in ex_mem_pipe.

## Test plan
- ADD a=5, imm=3, use_imm=1, rd=2 -> out_valid 2 cycles after accept, out_result=8, out_rd=2, out_rd_we=1.
- Store a=0x10, imm=0, b=0xBEEF, then load a=0x10 back-to-back -> load out_result=0xBEEF; the store reports out_rd_we=0.
- Hold out_ready=0 for 4 cycles with 3 instructions offered -> in_ready=0 after 2 accepts, no duplicate memory write, results in order once released.
- Assert reset while a store sits in S1 -> out_valid=0 next cycle; a following load of that address returns the pre-store value.
- SUB 0-1 at DATA_W=16 -> 0xFFFF. Address 0x1FF with MEM_DEPTH=256 -> accesses word 0xFF.
- With EX_MEM_FWD_EN: ADD rd=3=7, then next cycle ADD rs_a=3 (in_a=0) + imm 1 -> 8. A load to rd=4 followed by a use of rs_a=4 -> one-cycle in_ready stall, correct data.
